// File: rtl/dna_pkg.sv
// Shared definitions for the DNA match scheduler: base encoding, default widths, FSM states.
package dna_pkg;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_CH_W   = 2;
    localparam int unsigned DEF_CNT_W  = 8;
    localparam int unsigned DEF_LEN_W  = 12;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b11;
    localparam logic [1:0] BASE_T = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain0,
        StDrain1,
        StReport
    } sched_state_e;

endpackage

// File: rtl/dna_match_scheduler_if.sv
// Bundles the requester streams, the shared engine port and the result port.
interface dna_match_scheduler_if #(
    parameter int unsigned NUM_CH = dna_pkg::DEF_NUM_CH,
    parameter int unsigned CH_W   = dna_pkg::DEF_CH_W,
    parameter int unsigned CNT_W  = dna_pkg::DEF_CNT_W,
    parameter int unsigned LEN_W  = dna_pkg::DEF_LEN_W
);
    logic [NUM_CH-1:0]   s_valid;
    logic [NUM_CH-1:0]   s_ready;
    logic [2*NUM_CH-1:0] s_base;
    logic [NUM_CH-1:0]   s_last;
    logic                mt_clr;
    logic                mt_valid;
    logic [1:0]          mt_base;
    logic                mt_match;
    logic                res_valid;
    logic                res_ready;
    logic [CH_W-1:0]     res_ch;
    logic [CNT_W-1:0]    res_count;
    logic [LEN_W-1:0]    res_len;

    // Scheduler side.
    modport master (
        input  s_valid, s_base, s_last, mt_match, res_ready,
        output s_ready, mt_clr, mt_valid, mt_base, res_valid, res_ch, res_count, res_len
    );

    // Requesters, engine and result consumer side.
    modport slave (
        output s_valid, s_base, s_last, mt_match, res_ready,
        input  s_ready, mt_clr, mt_valid, mt_base, res_valid, res_ch, res_count, res_len
    );
endinterface

// File: rtl/dna_rr_arbiter.sv
// Combinational round-robin pick: first request at or after (last_i + 1) mod NUM_CH.
module dna_rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   last_i,
    output logic [CH_W-1:0]   grant_o,
    output logic              any_o
);
    int unsigned     idx;
    logic [CH_W-1:0] idx_c;

    // Scan the channels in wrap-around order starting after the previous owner.
    always_comb begin
        grant_o = last_i;
        any_o   = 1'b0;
        idx     = 0;
        idx_c   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx   = (32'(last_i) + k) % NUM_CH;
            idx_c = idx[CH_W-1:0];
            if (!any_o && req_i[idx_c]) begin
                any_o   = 1'b1;
                grant_o = idx_c;
            end
        end
    end
endmodule

// File: rtl/dna_match_scheduler.sv
// Round-robin sharing of one DNA match engine between NUM_CH base streams, one frame per grant.
module dna_match_scheduler
    import dna_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned CH_W   = DEF_CH_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input logic                   clk,
    input logic                   rst_n,
    dna_match_scheduler_if.master bus_io
);
    sched_state_e      state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [NUM_CH-1:0] s_ready_q, s_ready_d;
    logic              mt_clr_q, mt_clr_d;
    logic              mt_valid_q, mt_valid_d;
    logic [1:0]        mt_base_q, mt_base_d;
    logic              res_valid_q, res_valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic [CH_W-1:0]   arb_grant;
    logic              arb_any;
    logic [NUM_CH-1:0] grant_oh;
    logic              beat;
    logic [1:0]        g_base;

    dna_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_i   (bus_io.s_valid),
        .last_i  (last_q),
        .grant_o (arb_grant),
        .any_o   (arb_any)
    );

    assign grant_oh = NUM_CH'(1) << grant_q;
    assign beat     = bus_io.s_valid[grant_q] & s_ready_q[grant_q];
    assign g_base   = bus_io.s_base[{grant_q, 1'b0} +: 2];

    // Next-state and registered-output logic for the frame scheduler.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        s_ready_d   = '0;
        mt_clr_d    = 1'b0;
        mt_valid_d  = 1'b0;
        mt_base_d   = beat ? g_base : mt_base_q;
        res_valid_d = 1'b0;
        count_d     = count_q;
        len_d       = len_q;

        // Matches for the last base trail by two cycles, so the drain states keep counting.
        if ((state_q == StStream || state_q == StDrain0 || state_q == StDrain1) &&
            bus_io.mt_match && count_q != '1) begin
            count_d = count_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    grant_d  = arb_grant;
                    mt_clr_d = 1'b1;
                    state_d  = StClear;
                end
            end
            StClear: begin
                count_d   = '0;
                len_d     = '0;
                s_ready_d = grant_oh;
                state_d   = StStream;
            end
            StStream: begin
                s_ready_d = grant_oh;
                if (beat) begin
                    mt_valid_d = 1'b1;
                    if (len_q != '1) begin
                        len_d = len_q + 1'b1;
                    end
                    if (bus_io.s_last[grant_q]) begin
                        s_ready_d = '0;
                        state_d   = StDrain0;
                    end
                end
            end
            StDrain0: begin
                state_d = StDrain1;
            end
            StDrain1: begin
                res_valid_d = 1'b1;
                state_d     = StReport;
            end
            StReport: begin
                if (bus_io.res_ready) begin
                    last_d  = grant_q;
                    state_d = StIdle;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
            s_ready_q   <= '0;
            mt_clr_q    <= 1'b0;
            mt_valid_q  <= 1'b0;
            mt_base_q   <= '0;
            res_valid_q <= 1'b0;
            count_q     <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            s_ready_q   <= s_ready_d;
            mt_clr_q    <= mt_clr_d;
            mt_valid_q  <= mt_valid_d;
            mt_base_q   <= mt_base_d;
            res_valid_q <= res_valid_d;
            count_q     <= count_d;
            len_q       <= len_d;
        end
    end

    assign bus_io.s_ready   = s_ready_q;
    assign bus_io.mt_clr    = mt_clr_q;
    assign bus_io.mt_valid  = mt_valid_q;
    assign bus_io.mt_base   = mt_base_q;
    assign bus_io.res_valid = res_valid_q;
    assign bus_io.res_ch    = grant_q;
    assign bus_io.res_count = count_q;
    assign bus_io.res_len   = len_q;
endmodule

// File: tb/tb_dna_match_scheduler.sv
// Bench for dna_match_scheduler: ACGT-matching engine model, per-channel stream drivers,
// a frame-level result model and a per-cycle compare process.
module tb_dna_match_scheduler;
    import dna_pkg::*;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CH_W    = 2;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned LEN_W   = 12;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam int          LEN_MAX = (1 << LEN_W) - 1;
    localparam logic [7:0]  PATTERN = {BASE_A, BASE_C, BASE_G, BASE_T};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    dna_match_scheduler_if #(
        .NUM_CH (NUM_CH), .CH_W (CH_W), .CNT_W (CNT_W), .LEN_W (LEN_W)
    ) bus ();

    dna_match_scheduler #(
        .NUM_CH (NUM_CH), .CH_W (CH_W), .CNT_W (CNT_W), .LEN_W (LEN_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Engine: flags the base that completes A,C,G,T since the last clear, one cycle later.
    logic [5:0] eng_win;
    int         eng_fill;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_win <= '0; eng_fill <= 0; bus.mt_match <= 1'b0;
        end else if (bus.mt_clr) begin
            eng_win <= '0; eng_fill <= 0; bus.mt_match <= 1'b0;
        end else if (bus.mt_valid) begin
            eng_win      <= {eng_win[3:0], bus.mt_base};
            eng_fill     <= (eng_fill < 3) ? eng_fill + 1 : 3;
            bus.mt_match <= (eng_fill >= 3) && ({eng_win, bus.mt_base} == PATTERN);
        end else begin
            bus.mt_match <= 1'b0;
        end
    end

    // Per-channel beat queues: {valid, last, base[1:0]}; a valid=0 entry is a one-cycle bubble.
    logic [3:0]        drv_mem [NUM_CH][512];
    int                drv_head [NUM_CH];
    int                drv_tail [NUM_CH];
    logic [NUM_CH-1:0] drv_adv;

    initial begin
        bus.s_valid = '0; bus.s_base = '0; bus.s_last = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                drv_adv[c] = rst_n && (drv_head[c] < drv_tail[c]) &&
                             (!drv_mem[c][drv_head[c]][3] || (bus.s_valid[c] && bus.s_ready[c]));
            end
            @(posedge clk);
            #1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (drv_adv[c] && drv_head[c] < drv_tail[c]) drv_head[c]++;
                if (drv_head[c] < drv_tail[c]) begin
                    bus.s_valid[c]      = drv_mem[c][drv_head[c]][3];
                    bus.s_last[c]       = drv_mem[c][drv_head[c]][2];
                    bus.s_base[2*c +: 2] = drv_mem[c][drv_head[c]][1:0];
                end else begin
                    bus.s_valid[c] = 1'b0;
                    bus.s_last[c]  = 1'b0;
                end
            end
        end
    end

    // Frame-level model: pending results per channel plus the round-robin owner.
    int         bld_n [NUM_CH];
    int         bld_m [NUM_CH];
    logic [7:0] bld_hist [NUM_CH];
    int         exp_cnt [NUM_CH][16];
    int         exp_len [NUM_CH][16];
    int         exp_head [NUM_CH];
    int         exp_tail [NUM_CH];
    int         last_served = NUM_CH - 1;

    task automatic push_beat(input int c, input logic [1:0] b, input logic last);
        drv_mem[c][drv_tail[c]] = {1'b1, last, b};
        drv_tail[c]++;
        bld_hist[c] = {bld_hist[c][5:0], b};
        bld_n[c]++;
        if (bld_n[c] >= 4 && bld_hist[c] == PATTERN) bld_m[c]++;
        if (last) begin
            exp_cnt[c][exp_tail[c]] = (bld_m[c] > CNT_MAX) ? CNT_MAX : bld_m[c];
            exp_len[c][exp_tail[c]] = (bld_n[c] > LEN_MAX) ? LEN_MAX : bld_n[c];
            exp_tail[c]++;
            bld_n[c] = 0; bld_m[c] = 0; bld_hist[c] = '0;
        end
    endtask

    task automatic push_bubble(input int c);
        drv_mem[c][drv_tail[c]] = 4'b0000;
        drv_tail[c]++;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            drv_head[c] = 0; drv_tail[c] = 0;
            exp_head[c] = 0; exp_tail[c] = 0;
            bld_n[c] = 0; bld_m[c] = 0; bld_hist[c] = '0;
        end
        last_served = NUM_CH - 1;
    endtask

    function automatic int model_next();
        for (int k = 1; k <= NUM_CH; k++) begin
            int c = (last_served + k) % NUM_CH;
            if (exp_tail[c] > exp_head[c]) return c;
        end
        return -1;
    endfunction

    // Compare process, sampled on the falling edge.
    int              obs_n = 0;
    int              obs_ch [32];
    int              obs_cnt [32];
    int              obs_len [32];
    int              clr_seen = 0;
    int              pick;
    logic            hold_prev = 1'b0;
    logic [CH_W-1:0] ch_prev;
    logic [CNT_W-1:0] cnt_prev;
    logic [LEN_W-1:0] len_prev;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 1'b0;
                clr_seen  = 0;
            end else begin
                pick = model_next();
                if (bus.s_ready != '0)
                    chk("s_ready_grant", 32'(bus.s_ready), (pick >= 0) ? (1 << pick) : 0);
                if (bus.mt_clr) begin
                    clr_seen++;
                    chk("clr_vs_valid", 32'(bus.mt_valid), 0);
                end
                if (bus.mt_valid) chk("clr_once_before_valid", clr_seen, 1);
                if (hold_prev) begin
                    chk("res_hold_valid", 32'(bus.res_valid), 1);
                    chk("res_hold_ch", 32'(bus.res_ch), 32'(ch_prev));
                    chk("res_hold_count", 32'(bus.res_count), 32'(cnt_prev));
                    chk("res_hold_len", 32'(bus.res_len), 32'(len_prev));
                end
                if (bus.res_valid) begin
                    chk("res_no_grant", 32'({bus.mt_clr, bus.s_ready}), 0);
                    chk("res_ch", 32'(bus.res_ch), pick);
                    if (pick >= 0) begin
                        chk("res_count", 32'(bus.res_count), exp_cnt[pick][exp_head[pick]]);
                        chk("res_len", 32'(bus.res_len), exp_len[pick][exp_head[pick]]);
                    end
                    if (bus.res_ready) begin
                        if (obs_n < 32) begin
                            obs_ch[obs_n]  = int'(bus.res_ch);
                            obs_cnt[obs_n] = int'(bus.res_count);
                            obs_len[obs_n] = int'(bus.res_len);
                        end
                        obs_n++;
                        if (pick >= 0) begin
                            exp_head[pick]++;
                            last_served = pick;
                        end
                        clr_seen = 0;
                    end
                end
                hold_prev = bus.res_valid && !bus.res_ready;
                ch_prev   = bus.res_ch;
                cnt_prev  = bus.res_count;
                len_prev  = bus.res_len;
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(bus.s_ready), 0);
        chk({tag, "_mt_clr"}, 32'(bus.mt_clr), 0);
        chk({tag, "_mt_valid"}, 32'(bus.mt_valid), 0);
        chk({tag, "_mt_base"}, 32'(bus.mt_base), 0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        chk({tag, "_res_ch"}, 32'(bus.res_ch), 0);
        chk({tag, "_res_count"}, 32'(bus.res_count), 0);
        chk({tag, "_res_len"}, 32'(bus.res_len), 0);
    endtask

    task automatic wait_results(input int target, input int budget);
        int cyc = 0;
        while (obs_n < target && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("results_arrived", obs_n, target);
    endtask

    task automatic wait_sready(input int c, input int budget);
        int cyc = 0;
        while (!bus.s_ready[c] && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("s_ready_seen", 32'(bus.s_ready[c]), 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_obs(input int i, input int ch, input int cnt, input int len);
        chk("lit_ch", obs_ch[i], ch);
        chk("lit_count", obs_cnt[i], cnt);
        chk("lit_len", obs_len[i], len);
    endtask

    int         exp_order [6] = '{0, 1, 2, 3, 0, 2};
    logic [1:0] pat [4] = '{BASE_A, BASE_C, BASE_G, BASE_T};
    int         base_i;

    initial begin
        bus.res_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single frame with no match.
        push_beat(0, BASE_C, 1'b0); push_beat(0, BASE_C, 1'b0);
        push_beat(0, BASE_A, 1'b0); push_beat(0, BASE_G, 1'b1);
        wait_results(1, 60);
        chk_obs(0, 0, 0, 4);

        // One match on the last base, visible only during the drain.
        push_beat(1, BASE_A, 1'b0); push_beat(1, BASE_C, 1'b0);
        push_beat(1, BASE_G, 1'b0); push_beat(1, BASE_T, 1'b1);
        wait_results(2, 60);
        chk_obs(1, 1, 1, 4);

        // Fairness: all channels request; ch0 and ch2 carry a second frame.
        pulse_reset();
        base_i = obs_n;
        for (int c = 0; c < NUM_CH; c++) begin
            push_beat(c, BASE_A, 1'b0); push_beat(c, BASE_C, 1'b1);
        end
        push_beat(0, BASE_G, 1'b0); push_beat(0, BASE_T, 1'b1);
        push_beat(2, BASE_T, 1'b0); push_beat(2, BASE_G, 1'b1);
        wait_results(base_i + 6, 200);
        for (int i = 0; i < 6; i++) begin
            chk("rr_order", obs_ch[base_i + i], exp_order[i]);
            chk("rr_len", obs_len[base_i + i], 2);
        end

        // Bubbles inside the frame, then result backpressure with ch1 waiting.
        base_i = obs_n;
        bus.res_ready = 1'b0;
        push_beat(0, BASE_A, 1'b0);
        push_bubble(0); push_bubble(0); push_bubble(0);
        push_beat(0, BASE_C, 1'b0); push_beat(0, BASE_G, 1'b0); push_beat(0, BASE_T, 1'b1);
        wait_sready(0, 20);
        push_beat(1, BASE_G, 1'b0); push_beat(1, BASE_G, 1'b1);
        for (int cyc = 0; cyc < 40 && !bus.res_valid; cyc++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_res_valid", 32'(bus.res_valid), 1);
        repeat (5) @(posedge clk);
        #1 bus.res_ready = 1'b1;
        wait_results(base_i + 2, 60);
        chk_obs(base_i, 0, 1, 4);
        chk_obs(base_i + 1, 1, 0, 2);

        // Saturation: 300 bases of ACGT repeated gives 75 matches, clipped to 63.
        base_i = obs_n;
        for (int i = 0; i < 300; i++) push_beat(3, pat[i % 4], (i == 299));
        wait_results(base_i + 1, 400);
        chk_obs(base_i, 3, 63, 300);

        // Reset in the middle of a ch2 frame.
        for (int i = 0; i < 30; i++) push_beat(2, BASE_A, (i == 29));
        wait_sready(2, 20);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("midreset");
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base_i = obs_n;
        push_beat(0, BASE_C, 1'b0); push_beat(0, BASE_G, 1'b1);
        push_beat(2, BASE_A, 1'b0); push_beat(2, BASE_C, 1'b0);
        push_beat(2, BASE_G, 1'b0); push_beat(2, BASE_T, 1'b1);
        wait_results(base_i + 2, 100);
        chk_obs(base_i, 0, 0, 2);
        chk_obs(base_i + 1, 2, 1, 4);
        repeat (20) @(posedge clk);
        #1 chk("no_stale_result", obs_n, base_i + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
